e_mdu: RTL
==========

// Module: e_mdu
// PURPOSE
//  Execute-stage multiply/divide unit. Sits beside the ALU in E and owns the HI/LO registers.
//  Serves MULT/MULTU/DIV/DIVU/MTHI/MTLO, and drives MFHI/MFLO data onto the E result path.
//  That result feeds the E/M pipeline register.
//  Models multi-cycle latency with a busy counter; the hazard unit uses stall_req to freeze D.
// PARAMETERS
//  MULT_CYCLES  5   cycles busy is held after a MULT/MULTU start (>=1)
//  DIV_CYCLES   10  cycles busy is held after a DIV/DIVU start (>=1)
// PORTS
//  clk        in   1   clock
//  reset      in   1   synchronous, active-high
//  start      in   1   1-cycle pulse: E-stage instr is a MULT/MULTU/DIV/DIVU (or MADD-class) op
//  mdu_op     in   4   operation code (MDU_* constants in Define.v)
//  rs_val     in   32  forwarded rs operand
//  rt_val     in   32  forwarded rt operand
//  busy       out  1   registered; high while an operation is in flight
//  stall_req  out  1   combinational: busy | start; D-stage stall when D instr uses the MDU
//  hi         out  32  architectural HI
//  lo         out  32  architectural LO
//  mdu_result out  32  combinational: hi for MDU_MFHI, lo for MDU_MFLO, else 0
// BEHAVIOUR
//  Reset: busy=0, counter=0, hi=0, lo=0, pending regs=0. Reset mid-operation aborts it; HI/LO stay 0.
//  Start (start=1, busy=0):
//   - Compute the 64-bit result from the current rs_val/rt_val into pend_hi/pend_lo.
//   - busy<=1; counter<=MULT_CYCLES or DIV_CYCLES.
//  In flight: counter decrements every cycle. When counter==1, on that edge:
//   - hi<=pend_hi, lo<=pend_lo, busy<=0, counter<=0.
//   - busy is therefore high for exactly N cycles after the start edge.
//  start while busy=1: ignored. The hazard unit guarantees this never occurs; assert in sim.
//  MTHI/MTLO (start=0, busy=0): hi<=rs_val or lo<=rs_val next edge; no busy.
//   - MTHI/MTLO while busy=1: ignored. The hazard unit stalls it; assert in sim.
//  MFHI/MFLO: mdu_result reflects current hi/lo, 0 latency. The committed values are read.
//  Arithmetic:
//   - MULT: {hi,lo} = $signed(rs)*$signed(rt), 64-bit.
//   - MULTU: the same product, unsigned.
//   - DIV: lo = quotient truncated toward zero; hi = remainder, sign of dividend.
//     0x80000000 / -1: lo=0x80000000, hi=0.
//   - DIVU: lo = quotient, hi = remainder, unsigned.
//   - Divide by zero (rt_val==0): busy sequence runs normally; HI/LO unchanged at commit.
//  Unrecognised mdu_op with start=1: treated as no-op, no busy.
// CONFIGURATION
//  Macro MDU_MADD_EN:
//   - Defined: MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU are accepted as start ops, MULT latency.
//     {hi,lo} = {hi,lo} +/- product. Accumulate uses HI/LO at commit time, wrap modulo 2^64.
//   - Undefined: these codes are unrecognised and behave as no-ops.
// STRUCTURE
//  Define.v holds:
//   - MDU_NONE, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MFHI, MDU_MFLO, MDU_MTHI, MDU_MTLO
//   - MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU (4-bit encodings)
//   - default cycle counts
//  Sub-module mdu_busy_ctr: loadable down-counter with load value, busy, and done pulse.
//  The arithmetic and HI/LO commit stay in e_mdu.
// TESTING
//  1. MULT rs=0xFFFFFFFE(-2), rt=3:
//     busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy low on cycle 6.
//  2. MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles.
//  3. DIV rs=-7 (0xFFFFFFF9), rt=2:
//     busy 10 cycles, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//     DIVU 7/0 -> hi/lo unchanged.
//  4. Reset asserted on cycle 3 of a DIV:
//     next edge busy=0, hi=lo=0; later MTHI 0x1234 -> hi=0x1234, mdu_result on MFHI=0x1234.
//  5. stall_req: high in the start cycle and every busy cycle, low the cycle busy drops.
//     MFLO issued after the drop reads the new lo.
//  6. MDU_MADD_EN builds: hi=0, lo=0xFFFFFFFF, MADDU rs=1, rt=1 -> hi=1, lo=0.
//     Non-MADD builds: the same op leaves busy=0 and HI/LO unchanged.

Source files
------------

// File: rtl/e_mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encodings, default latencies
// and op classification. Macro MDU_MADD_EN enables the MADD/MSUB accumulate ops.
package e_mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8,
    MDU_MADD  = 4'd9,
    MDU_MADDU = 4'd10,
    MDU_MSUB  = 4'd11,
    MDU_MSUBU = 4'd12
  } mdu_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // How the pending 64-bit value lands in {hi,lo} when the busy counter expires.
  typedef enum logic [1:0] {
    CMT_SET,
    CMT_ADD,
    CMT_SUB,
    CMT_KEEP
  } commit_e;

  function automatic logic is_mul_op(input logic [3:0] op);
    case (op)
      MDU_MULT, MDU_MULTU: return 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_if.sv
// E-stage <-> MDU signal bundle. The pipeline side is the master, the MDU the slave.
interface e_mdu_if;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mdu_result;

  modport master (
    output start, mdu_op, rs_val, rt_val,
    input  busy, stall_req, hi, lo, mdu_result
  );

  modport slave (
    input  start, mdu_op, rs_val, rt_val,
    output busy, stall_req, hi, lo, mdu_result
  );
endinterface

// File: rtl/e_mdu_busy_ctr.sv
// Loadable down-counter modelling MDU latency: busy stays high for load_val cycles after the
// load edge, and done flags the last busy cycle (the commit edge follows it).
module mdu_busy_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         busy,
  output logic         done
);

  logic [W-1:0] cnt;

  assign done = busy && (cnt == W'(1));

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (load) begin
      cnt  <= load_val;
      busy <= 1'b1;
    end else if (done) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (busy) begin
      cnt  <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit owning HI/LO. Results are computed at start, held in
// pending registers and committed when the busy counter expires. Macro: MDU_MADD_EN.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic    clk,
  input logic    reset,
  e_mdu_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic             busy, done, accept, is_mul, is_div;
  logic [CNT_W-1:0] load_val;
  logic [31:0]      hi, lo, divisor;
  logic [63:0]      smul, umul, op_res, pend;
  logic signed [31:0] squo, srem;
  commit_e          op_mode, pend_mode;

  assign is_mul   = is_mul_op(bus.mdu_op);
  assign is_div   = is_div_op(bus.mdu_op);
  assign accept   = bus.start && !busy && (is_mul || is_div);
  assign load_val = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  mdu_busy_ctr #(.W(CNT_W)) u_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (load_val),
    .busy     (busy),
    .done     (done)
  );

  // Divide-by-zero results are discarded, so a safe divisor just keeps the dividers defined.
  assign divisor = (bus.rt_val == 32'd0) ? 32'd1 : bus.rt_val;
  assign squo    = $signed(bus.rs_val) / $signed(divisor);
  assign srem    = $signed(bus.rs_val) % $signed(divisor);
  assign smul    = {{32{bus.rs_val[31]}}, bus.rs_val} * {{32{bus.rt_val[31]}}, bus.rt_val};
  assign umul    = {32'd0, bus.rs_val} * {32'd0, bus.rt_val};

  always_comb begin
    // NOTE: defaults first so no path through the case infers a latch.
    op_res  = '0;
    op_mode = CMT_SET;
    case (bus.mdu_op)
      MDU_MULT:  op_res = smul;
      MDU_MULTU: op_res = umul;
      MDU_DIV: begin
        if (bus.rt_val == 32'd0)
          op_mode = CMT_KEEP;
        else if (bus.rs_val == 32'h8000_0000 && bus.rt_val == 32'hFFFF_FFFF)
          op_res = {32'd0, 32'h8000_0000};
        else
          op_res = {srem, squo};
      end
      MDU_DIVU: begin
        if (bus.rt_val == 32'd0)
          op_mode = CMT_KEEP;
        else
          op_res = {bus.rs_val % bus.rt_val, bus.rs_val / bus.rt_val};
      end
`ifdef MDU_MADD_EN
      MDU_MADD:  begin op_res = smul; op_mode = CMT_ADD; end
      MDU_MADDU: begin op_res = umul; op_mode = CMT_ADD; end
      MDU_MSUB:  begin op_res = smul; op_mode = CMT_SUB; end
      MDU_MSUBU: begin op_res = umul; op_mode = CMT_SUB; end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi        <= '0;
      lo        <= '0;
      pend      <= '0;
      pend_mode <= CMT_SET;
    end else begin
      if (accept) begin
        pend      <= op_res;
        pend_mode <= op_mode;
      end
      // Accumulate reads HI/LO as they stand at commit, not at start.
      if (done) begin
        case (pend_mode)
          CMT_SET: {hi, lo} <= pend;
          CMT_ADD: {hi, lo} <= {hi, lo} + pend;
          CMT_SUB: {hi, lo} <= {hi, lo} - pend;
          default: ;
        endcase
      end else if (!busy && !bus.start) begin
        if (bus.mdu_op == MDU_MTHI) hi <= bus.rs_val;
        if (bus.mdu_op == MDU_MTLO) lo <= bus.rs_val;
      end
    end
  end

  always_comb begin
    bus.mdu_result = '0;
    if (bus.mdu_op == MDU_MFHI) bus.mdu_result = hi;
    if (bus.mdu_op == MDU_MFLO) bus.mdu_result = lo;
  end

  assign bus.busy      = busy;
  assign bus.stall_req = busy | bus.start;
  assign bus.hi        = hi;
  assign bus.lo        = lo;

  // The hazard unit never lets a new MDU op reach E while one is in flight.
  a_no_start_busy: assert property (@(posedge clk) disable iff (reset) !(bus.start && busy));
  a_no_mt_busy: assert property (@(posedge clk) disable iff (reset)
    !(busy && (bus.mdu_op == MDU_MTHI || bus.mdu_op == MDU_MTLO)));

endmodule
